// File: rtl/sa_pkg.sv
// Shared definitions for the systolic GEMM engine: sequencer states, a
// width helper and the accumulator saturation bounds used when the
// SYSTOLIC_SATURATE_EN build option is defined.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_t;

    // Bit width needed to hold values 0..value-1, never less than one bit.
    function automatic int safe_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Largest signed value of a w-bit accumulator (low w bits are meaningful).
    function automatic logic [127:0] sat_max(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    // Smallest signed value of a w-bit accumulator as a w-bit pattern.
    function automatic logic [127:0] sat_min(input int w);
        return 128'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/systolic_gemm_engine_if.sv
// Operand/result streaming bundle of the systolic GEMM engine. The master
// side issues jobs and operand beats and consumes result rows; the slave
// side is the engine.
interface systolic_gemm_engine_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 256
);
    import sa_pkg::*;

    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = safe_clog2(ROWS);

    logic                       start;
    logic [KW-1:0]              k_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_WIDTH-1:0] in_row;
    logic [COLS*DATA_WIDTH-1:0] in_col;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS*ACC_WIDTH-1:0]  out_row;
    logic [IW-1:0]              out_idx;
    logic                       busy;
    logic                       done;

    modport master (
        output start, k_len, in_valid, in_row, in_col, out_ready,
        input  in_ready, out_valid, out_row, out_idx, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_row, in_col, out_ready,
        output in_ready, out_valid, out_row, out_idx, busy, done
    );

endinterface

// File: rtl/sa_pe.sv
// Single output-stationary MAC cell. A moves right and B moves down through
// registered pass-throughs; the accumulator adds the full-precision product.
// Define SYSTOLIC_SATURATE_EN to clamp each accumulate instead of wrapping.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_clr,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_a,
    output logic signed [DATA_WIDTH-1:0] o_b,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [DATA_WIDTH-1:0]   r_a;
    logic signed [DATA_WIDTH-1:0]   r_b;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;
    logic signed [2*DATA_WIDTH-1:0] w_prod;

    assign w_prod = i_a * i_b;

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] w_sum;

    // One guard bit exposes overflow; its sign picks the bound to clamp to
    assign w_sum = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_prod);

    // Clamp on overflow, otherwise keep the exact sum
    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
            w_acc_next = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    // Signed size cast sign-extends the product; the add wraps naturally
    assign w_acc_next = r_acc + ACC_WIDTH'(w_prod);
`endif

    // Pass-through registers and accumulator advance only when the grid steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= w_acc_next;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_gemm_engine.sv
// Output-stationary ROWS x COLS systolic GEMM engine: input skewing, a
// K-length load/flush sequencer and a row-by-row result drain.
// Build option SYSTOLIC_SATURATE_EN (see sa_pe) selects saturating accumulate.
module systolic_gemm_engine
    import sa_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_gemm_engine_if.slave  io_bus
);

    localparam int KW        = $clog2(K_MAX + 1);
    localparam int IW        = safe_clog2(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int CW        = safe_clog2(((K_MAX > FLUSH_LEN) ? K_MAX : FLUSH_LEN) + 1);

    sa_state_t     r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [CW-1:0] r_k_len, w_k_len_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [CW-1:0] w_k_clamped;
    logic          w_adv;
    logic          w_clr;
    logic          w_inject;

    logic signed [DATA_WIDTH-1:0] w_a_h [ROWS][COLS+1];
    logic signed [DATA_WIDTH-1:0] w_b_v [ROWS+1][COLS];
    logic signed [ACC_WIDTH-1:0]  w_acc [ROWS][COLS];

    assign w_k_clamped = (io_bus.k_len > KW'(K_MAX)) ? CW'(K_MAX) : CW'(io_bus.k_len);

    // Sequencer state, beat/flush counter, captured length and drain row index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k_len <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_k_len <= w_k_len_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next state and grid control: step on accepted beats or every flush cycle
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_k_len_next = r_k_len;
        w_idx_next   = r_idx;
        w_adv        = 1'b0;
        w_clr        = 1'b0;
        w_inject     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (io_bus.start) begin
                    w_clr        = 1'b1;
                    w_k_len_next = w_k_clamped;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = (w_k_clamped == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (io_bus.in_valid) begin
                    w_adv    = 1'b1;
                    w_inject = 1'b1;
                    if (r_cnt == r_k_len - CW'(1)) begin
                        w_cnt_next   = '0;
                        w_state_next = FLUSH;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            FLUSH: begin
                w_adv = 1'b1;
                if (r_cnt == CW'(FLUSH_LEN - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = DRAIN;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (io_bus.out_ready) begin
                    if (r_idx == IW'(ROWS - 1)) begin
                        w_idx_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign io_bus.in_ready  = (r_state == LOAD);
    assign io_bus.out_valid = (r_state == DRAIN);
    assign io_bus.out_idx   = r_idx;
    assign io_bus.busy      = (r_state != IDLE);
    assign io_bus.done      = (r_state == DRAIN) && io_bus.out_ready && (r_idx == IW'(ROWS - 1));

    generate
        // Row lane gi is delayed gi steps so A and B meet on the anti-diagonal
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_skew
            logic signed [DATA_WIDTH-1:0] w_inj;
            assign w_inj = w_inject ? io_bus.in_row[(ROWS-1-gi)*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gi == 0) begin : g_direct
                assign w_a_h[gi][0] = w_inj;
            end else begin : g_delay
                logic signed [DATA_WIDTH-1:0] r_dly [gi];
                // Shift register that moves only with the grid
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || w_clr) begin
                        for (int s = 0; s < gi; s++) r_dly[s] <= '0;
                    end else if (w_adv) begin
                        r_dly[0] <= w_inj;
                        for (int s = 1; s < gi; s++) r_dly[s] <= r_dly[s-1];
                    end
                end
                assign w_a_h[gi][0] = r_dly[gi-1];
            end
        end

        // Column lane gj is delayed gj steps
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col_skew
            logic signed [DATA_WIDTH-1:0] w_inj;
            assign w_inj = w_inject ? io_bus.in_col[(COLS-1-gj)*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gj == 0) begin : g_direct
                assign w_b_v[0][gj] = w_inj;
            end else begin : g_delay
                logic signed [DATA_WIDTH-1:0] r_dly [gj];
                // Shift register that moves only with the grid
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || w_clr) begin
                        for (int s = 0; s < gj; s++) r_dly[s] <= '0;
                    end else if (w_adv) begin
                        r_dly[0] <= w_inj;
                        for (int s = 1; s < gj; s++) r_dly[s] <= r_dly[s-1];
                    end
                end
                assign w_b_v[0][gj] = r_dly[gj-1];
            end
        end

        for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_row
            for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_col
                sa_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .i_en  (w_adv),
                    .i_clr (w_clr),
                    .i_a   (w_a_h[gi][gj]),
                    .i_b   (w_b_v[gi][gj]),
                    .o_a   (w_a_h[gi][gj+1]),
                    .o_b   (w_b_v[gi+1][gj]),
                    .o_acc (w_acc[gi][gj])
                );
            end
        end

        // Result row is forced to zero outside DRAIN so idle output is quiet
        for (genvar gj = 0; gj < COLS; gj++) begin : g_out
            assign io_bus.out_row[(COLS-1-gj)*ACC_WIDTH +: ACC_WIDTH] =
                (r_state == DRAIN) ? w_acc[r_idx][gj] : '0;
        end
    endgenerate

endmodule
